// File: rtl/freq_code_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_code_ctrl_pkg
//  Description : Shared state encoding and default widths for the DCO
//                frequency-code controller and its lock-detect integration.
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_code_ctrl_pkg;

    localparam int unsigned CODE_BITS_DEF  = 8;
    localparam int unsigned COUNT_BITS_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2
    } fcc_state_e;

endpackage : freq_code_ctrl_pkg
`default_nettype wire

// File: rtl/freq_code_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : freq_code_ctrl_if
//  Description : Measurement inputs and code/status outputs of the DCO
//                frequency-code controller. The master side supplies the
//                target, the measured counts and the enable; the slave side
//                (the controller) returns the code and its status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface freq_code_ctrl_if
    import freq_code_ctrl_pkg::*;
#(
    parameter int unsigned CODE_BITS  = CODE_BITS_DEF,
    parameter int unsigned COUNT_BITS = COUNT_BITS_DEF
);

    logic                  enable;
    logic [COUNT_BITS-1:0] fcw;
    logic [COUNT_BITS-1:0] dcoCount;
    logic                  dcoCountValid;
    logic [2:0]            tolerance;
    logic [CODE_BITS-1:0]  freqCode;
    logic                  freqUp;
    logic                  freqDn;
    logic                  searching;
    logic                  saturated;

    modport master (
        output enable, fcw, dcoCount, dcoCountValid, tolerance,
        input  freqCode, freqUp, freqDn, searching, saturated
    );

    modport slave (
        input  enable, fcw, dcoCount, dcoCountValid, tolerance,
        output freqCode, freqUp, freqDn, searching, saturated
    );

endinterface : freq_code_ctrl_if
`default_nettype wire

// File: rtl/freq_code_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : freq_code_ctrl
//  Description : DCO frequency-code loop. A binary search (one bit per
//                accepted count sample, MSB first) finds the code, then a
//                +/-1 tracking loop with a programmable dead-band holds it.
//                The first sample after any code change measured the old
//                code and is discarded. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_code_ctrl
    import freq_code_ctrl_pkg::*;
#(
    parameter int unsigned CODE_BITS  = CODE_BITS_DEF,
    parameter int unsigned COUNT_BITS = COUNT_BITS_DEF
) (
    input  logic            clock,
    input  logic            reset,   // synchronous, active low
    freq_code_ctrl_if.slave bus
);

    localparam int unsigned          IDX_BITS   = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
    localparam logic [CODE_BITS-1:0] c_MID      = {1'b1, {(CODE_BITS-1){1'b0}}};
    localparam logic [CODE_BITS-1:0] c_CODE_ONE = CODE_BITS'(1);
    localparam logic [IDX_BITS-1:0]  c_MSB_IDX  = IDX_BITS'(CODE_BITS-1);
    localparam logic [IDX_BITS-1:0]  c_IDX_ONE  = IDX_BITS'(1);

    fcc_state_e            state_q, state_d;
    logic [CODE_BITS-1:0]  code_q,  code_d;
    logic [IDX_BITS-1:0]   idx_q,   idx_d;
    logic                  stale_q, stale_d;
    logic                  up_q,    up_d;
    logic                  dn_q,    dn_d;
    logic                  srch_q,  srch_d;
    logic                  sat_q,   sat_d;
    logic [CODE_BITS-1:0]  trial;

    // One extra bit keeps the count difference from wrapping.
    logic signed [COUNT_BITS:0] w_err;
    logic signed [COUNT_BITS:0] w_tol;
    logic                       w_too_slow;
    logic                       w_too_fast;

    assign w_err      = $signed({1'b0, bus.dcoCount}) - $signed({1'b0, bus.fcw});
    assign w_tol      = $signed({{(COUNT_BITS-2){1'b0}}, bus.tolerance});
    assign w_too_slow = (w_err < -w_tol);
    assign w_too_fast = (w_err >  w_tol);

    // Next-state, next-code and status computation.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        stale_d = stale_q;
        sat_d   = sat_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        trial   = code_q;

        if (!bus.enable) begin
            // Leaving the loop parks the code at mid-scale silently.
            state_d = ST_IDLE;
            code_d  = c_MID;
            idx_d   = c_MSB_IDX;
            stale_d = 1'b0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                    code_d  = c_MID;
                    idx_d   = c_MSB_IDX;
                    stale_d = 1'b0;
                    sat_d   = 1'b0;
                end
                ST_SEARCH: begin
                    if (bus.dcoCountValid) begin
                        if (stale_q) begin
                            stale_d = 1'b0;
                        end else begin
                            // DCO at or above target: this bit overshoots.
                            if (w_err >= 0) begin
                                trial[idx_q] = 1'b0;
                            end
                            if (idx_q != '0) begin
                                trial[idx_q - c_IDX_ONE] = 1'b1;
                                idx_d = idx_q - c_IDX_ONE;
                            end else begin
                                state_d = ST_TRACK;
                            end
                            code_d = trial;
                        end
                    end
                end
                ST_TRACK: begin
                    if (bus.dcoCountValid) begin
                        if (stale_q) begin
                            stale_d = 1'b0;
                        end else if (w_too_slow) begin
                            if (code_q == '1) begin
                                sat_d = 1'b1;
                            end else begin
                                code_d = code_q + c_CODE_ONE;
                                sat_d  = 1'b0;
                            end
                        end else if (w_too_fast) begin
                            if (code_q == '0) begin
                                sat_d = 1'b1;
                            end else begin
                                code_d = code_q - c_CODE_ONE;
                                sat_d  = 1'b0;
                            end
                        end else begin
                            sat_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    code_d  = c_MID;
                    idx_d   = c_MSB_IDX;
                    stale_d = 1'b0;
                    sat_d   = 1'b0;
                end
            endcase

            // Any real code change invalidates the window in flight and
            // reports its direction.
            if ((state_q != ST_IDLE) && (code_d != code_q)) begin
                stale_d = 1'b1;
                up_d    = (code_d > code_q);
                dn_d    = (code_d < code_q);
            end
        end

        srch_d = (state_d == ST_SEARCH);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            code_q  <= c_MID;
            idx_q   <= c_MSB_IDX;
            stale_q <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            srch_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            stale_q <= stale_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            srch_q  <= srch_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.freqCode  = code_q;
    assign bus.freqUp    = up_q;
    assign bus.freqDn    = dn_q;
    assign bus.searching = srch_q;
    assign bus.saturated = sat_q;

endmodule : freq_code_ctrl
`default_nettype wire

// File: tb/tb_freq_code_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_code_ctrl
//  Description : Directed self-checking bench for freq_code_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_code_ctrl;

    logic clock;
    logic reset;

    freq_code_ctrl_if #(.CODE_BITS(8), .COUNT_BITS(12)) bus ();

    freq_code_ctrl #(.CODE_BITS(8), .COUNT_BITS(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    int both_seen  = 0;
    logic [7:0] cur;   // bench's expected current code

    always @(posedge clock) begin
        if (bus.freqUp && bus.freqDn) both_seen++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ecode,
                              input logic eup, input logic edn,
                              input logic esrch, input logic esat);
        check({tag, ".code"}, 32'(bus.freqCode),  32'(ecode));
        check({tag, ".up"},   32'(bus.freqUp),    32'(eup));
        check({tag, ".dn"},   32'(bus.freqDn),    32'(edn));
        check({tag, ".srch"}, 32'(bus.searching), 32'(esrch));
        check({tag, ".sat"},  32'(bus.saturated), 32'(esat));
    endtask

    // One accepted sample; when the code moves, the following sample
    // (a deliberately misleading count) must be thrown away.
    task automatic sample(input string tag, input logic [11:0] cnt,
                          input logic [7:0] ecode, input logic esrch, input logic esat);
        logic eup;
        logic edn;
        eup = (ecode > cur);
        edn = (ecode < cur);
        bus.dcoCount      = cnt;
        bus.dcoCountValid = 1'b1;
        step();
        bus.dcoCountValid = 1'b0;
        expect_out(tag, ecode, eup, edn, esrch, esat);
        if (ecode != cur) begin
            bus.dcoCount      = cnt ^ 12'hA5A;
            bus.dcoCountValid = 1'b1;
            step();
            bus.dcoCountValid = 1'b0;
            expect_out({tag, ".stale"}, ecode, 1'b0, 1'b0, esrch, esat);
        end
        cur = ecode;
    endtask

    // Expected code after each accepted search sample.
    // DCO = 4*code+500 vs 1000: err >= 0 from code 125 up, so bit 0 is
    // cleared when 125 is tried and the search lands on 124.
    logic [7:0] exp_a [8] = '{8'd64, 8'd96, 8'd112, 8'd120, 8'd124, 8'd126, 8'd125, 8'd124};
    // Always too fast: every bit cleared.
    logic [7:0] exp_b [8] = '{8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1, 8'd0};
    // Always too slow: every bit kept.
    logic [7:0] exp_c [8] = '{8'd192, 8'd224, 8'd240, 8'd248, 8'd252, 8'd254, 8'd255, 8'd255};

    initial begin
        reset             = 1'b0;
        bus.enable        = 1'b0;
        bus.fcw           = 12'd1000;
        bus.dcoCount      = 12'd0;
        bus.dcoCountValid = 1'b0;
        bus.tolerance     = 3'd2;
        cur               = 8'd128;

        step();
        step();
        expect_out("reset", 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- search A: model DCO 4*code+500 ----
        reset      = 1'b1;
        bus.enable = 1'b1;
        step();
        expect_out("enA", 8'd128, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sample($sformatf("srchA%0d", i), 12'(4 * int'(cur) + 500), exp_a[i], (i < 7), 1'b0);
        end

        // ---- tracking with dead-band 2 ----
        sample("trk_up1",   12'd996,  8'd125, 1'b0, 1'b0);  // err -4
        sample("trk_up2",   12'd994,  8'd126, 1'b0, 1'b0);  // err -6
        sample("trk_holdp", 12'd1002, 8'd126, 1'b0, 1'b0);  // err +2
        sample("trk_holdn", 12'd998,  8'd126, 1'b0, 1'b0);  // err -2
        sample("trk_dn",    12'd1003, 8'd125, 1'b0, 1'b0);  // err +3

        // ---- disable from TRACK ----
        bus.enable = 1'b0;
        step();
        expect_out("disA", 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
        cur = 8'd128;
        bus.enable = 1'b1;
        step();
        expect_out("enB", 8'd128, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- search B to code 0, then low saturation ----
        for (int i = 0; i < 8; i++) begin
            sample($sformatf("srchB%0d", i), 12'd1010, exp_b[i], (i < 7), 1'b0);
        end
        sample("sat0",     12'd1010, 8'd0, 1'b0, 1'b1);
        sample("sat0_clr", 12'd1001, 8'd0, 1'b0, 1'b0);

        bus.enable = 1'b0;
        step();
        expect_out("disB", 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
        cur = 8'd128;
        bus.enable = 1'b1;
        step();
        expect_out("enC", 8'd128, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- partial search, drop enable at bitIdx=4 with a coincident strobe ----
        for (int i = 0; i < 3; i++) begin
            sample($sformatf("partC%0d", i), 12'd990, exp_c[i], 1'b1, 1'b0);
        end
        bus.enable        = 1'b0;
        bus.dcoCount      = 12'd990;
        bus.dcoCountValid = 1'b1;
        step();
        bus.dcoCountValid = 1'b0;
        expect_out("drop", 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
        cur = 8'd128;
        bus.enable = 1'b1;
        step();
        expect_out("reen", 8'd128, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- full search C to all-ones, then high saturation ----
        for (int i = 0; i < 8; i++) begin
            sample($sformatf("srchC%0d", i), 12'd990, exp_c[i], (i < 7), 1'b0);
        end
        sample("sat255", 12'd990, 8'd255, 1'b0, 1'b1);

        // ---- reset coincident with a strobe that would move the code ----
        reset             = 1'b0;
        bus.dcoCount      = 12'd1010;
        bus.dcoCountValid = 1'b1;
        step();
        bus.dcoCountValid = 1'b0;
        expect_out("rst_trk", 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();

        check("never_both", 32'(both_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_freq_code_ctrl
`default_nettype wire
